// File: rtl/bb_msg_reader_pkg.sv
// Shared types and constants for the bounding-box message reader.
// Register map, FSM states and the corner-word layout live here.
package bb_msg_reader_pkg;

  typedef enum logic [3:0] {
    ID_RD,
    ID_WAIT,
    FLUSH,
    POLL_WAIT,
    STAT_RD,
    STAT_WAIT,
    HDR_RD,
    HDR_WAIT,
    TL_RD,
    TL_WAIT,
    BR_RD,
    BR_WAIT,
    FAULT
  } state_t;

  localparam logic [2:0]  ADDR_STATUS   = 3'd0;
  localparam logic [2:0]  ADDR_READ_MSG = 3'd1;
  localparam logic [2:0]  ADDR_READ_ID  = 3'd2;

  localparam logic [31:0] FLUSH_CMD     = 32'h0000_0010;
  localparam logic [7:0]  MSG_WORDS     = 8'd3;

  localparam logic [31:0] DEF_MSG_ID      = 32'h0052_4242;
  localparam logic [31:0] DEF_EXPECTED_ID = 32'h1234_EEE2;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
  } pt_t;

  // Corner word: x in [26:16], y in [10:0], spare bits dropped.
  function automatic pt_t unpack_pt(input logic [31:0] w);
    pt_t p;
    p.x = w[26:16];
    p.y = w[10:0];
    return p;
  endfunction

endpackage

// File: rtl/msg_poll_timer.sv
// 16-bit poll interval timer: load, count down, then flag expiry.
// The flag rises on the decrement issued while the count is already 0.
module msg_poll_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        dec,
  input  logic [15:0] load_val,
  output logic        zero
);

  logic [15:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      zero  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      zero  <= 1'b0;
    end else if (dec) begin
      if (count != '0) count <= count - 16'd1;
      zero <= (count == '0);
    end
  end

endmodule

// File: rtl/bb_msg_reader.sv
// Polls an image processor over a latency-1 bus and decodes
// bounding-box messages (header, top-left, bottom-right).
module bb_msg_reader
  import bb_msg_reader_pkg::*;
#(
  parameter logic [15:0] POLL_INTERVAL = 16'd1000,
  parameter logic [31:0] MSG_ID        = DEF_MSG_ID,
  parameter logic [31:0] EXPECTED_ID   = DEF_EXPECTED_ID
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic [10:0] bb_left,
  output logic [10:0] bb_top,
  output logic [10:0] bb_right,
  output logic [10:0] bb_bottom,
  output logic        bb_valid,
  output logic        bb_found,
  output logic        id_ok,
  output logic        fault,
  output logic [7:0]  resync_count
);

  state_t      state_q;
  state_t      state_d;
  pt_t         tl_q;
  pt_t         br_pt;
  logic        rd;
  logic        wr;
  logic [2:0]  addr;
  logic        t_load;
  logic        t_dec;
  logic        t_zero;
  logic        id_match;
  logic        hdr_match;
  logic        have_msg;

  msg_poll_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (t_load),
    .dec      (t_dec),
    .load_val (POLL_INTERVAL - 16'd1),
    .zero     (t_zero)
  );

  assign br_pt     = unpack_pt(m_readdata);
  assign id_match  = (m_readdata == EXPECTED_ID);
  assign hdr_match = (m_readdata == MSG_ID);
  assign have_msg  = (m_readdata[15:8] >= MSG_WORDS);

  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    wr      = 1'b0;
    addr    = ADDR_STATUS;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    unique case (state_q)
      ID_RD: begin
        rd      = 1'b1;
        addr    = ADDR_READ_ID;
        state_d = ID_WAIT;
      end
      ID_WAIT:
        state_d = id_match ? FLUSH : FAULT;
      FLUSH: begin
        wr      = 1'b1;
        t_load  = 1'b1;
        state_d = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (t_zero) state_d = STAT_RD;
        else        t_dec   = 1'b1;
      end
      STAT_RD: begin
        rd      = 1'b1;
        state_d = STAT_WAIT;
      end
      STAT_WAIT: begin
        if (have_msg) begin
          state_d = HDR_RD;
        end else begin
          t_load  = 1'b1;
          state_d = POLL_WAIT;
        end
      end
      HDR_RD: begin
        rd      = 1'b1;
        addr    = ADDR_READ_MSG;
        state_d = HDR_WAIT;
      end
      HDR_WAIT: begin
        if (hdr_match) begin
          state_d = TL_RD;
        end else begin
          t_load  = 1'b1;
          state_d = POLL_WAIT;
        end
      end
      TL_RD: begin
        rd      = 1'b1;
        addr    = ADDR_READ_MSG;
        state_d = TL_WAIT;
      end
      TL_WAIT:
        state_d = BR_RD;
      BR_RD: begin
        rd      = 1'b1;
        addr    = ADDR_READ_MSG;
        state_d = BR_WAIT;
      end
      BR_WAIT: begin
        t_load  = 1'b1;
        state_d = POLL_WAIT;
      end
      FAULT:
        state_d = FAULT;
      default:
        state_d = ID_RD;
    endcase
  end

  // Strobes are gated by reset so the ID_RD reset state stays silent.
  assign m_read       = rd & reset_n;
  assign m_write      = wr & reset_n;
  assign m_chipselect = m_read | m_write;
  assign m_address    = m_read ? addr : 3'd0;
  assign m_writedata  = m_write ? FLUSH_CMD : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ID_RD;
      tl_q         <= '0;
      bb_left      <= '0;
      bb_top       <= '0;
      bb_right     <= '0;
      bb_bottom    <= '0;
      bb_valid     <= 1'b0;
      bb_found     <= 1'b0;
      id_ok        <= 1'b0;
      fault        <= 1'b0;
      resync_count <= '0;
    end else begin
      state_q  <= state_d;
      bb_valid <= 1'b0;
      if (state_q == ID_WAIT) begin
        if (id_match) id_ok <= 1'b1;
        else          fault <= 1'b1;
      end
      if (state_q == HDR_WAIT && !hdr_match && resync_count != 8'hFF)
        resync_count <= resync_count + 8'd1;
      if (state_q == TL_WAIT)
        tl_q <= br_pt;
      if (state_q == BR_WAIT) begin
        bb_left   <= tl_q.x;
        bb_top    <= tl_q.y;
        bb_right  <= br_pt.x;
        bb_bottom <= br_pt.y;
        bb_valid  <= 1'b1;
        bb_found  <= (tl_q.x <= br_pt.x) && (tl_q.y <= br_pt.y);
      end
    end
  end

endmodule

// File: tb/tb_bb_msg_reader.sv
// Bench for bb_msg_reader: FIFO slave model plus a box-level
// reference built from the message words the bench sends.
module tb_bb_msg_reader;

  localparam int          P       = 5;
  localparam logic [31:0] RBB     = 32'h0052_4242;
  localparam logic [31:0] GOOD_ID = 32'h1234_EEE2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m_chipselect;
  logic        m_read;
  logic        m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = '0;
  logic [10:0] bb_left;
  logic [10:0] bb_top;
  logic [10:0] bb_right;
  logic [10:0] bb_bottom;
  logic        bb_valid;
  logic        bb_found;
  logic        id_ok;
  logic        fault;
  logic [7:0]  resync_count;

  bb_msg_reader #(
    .POLL_INTERVAL (16'(P))
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .m_chipselect (m_chipselect),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_address    (m_address),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .bb_left      (bb_left),
    .bb_top       (bb_top),
    .bb_right     (bb_right),
    .bb_bottom    (bb_bottom),
    .bb_valid     (bb_valid),
    .bb_found     (bb_found),
    .id_ok        (id_ok),
    .fault        (fault),
    .resync_count (resync_count)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave: ID register, STATUS word count, message FIFO, flush.
  logic [31:0] fifo[$];
  logic [31:0] id_val = GOOD_ID;

  always @(posedge clk) begin
    if (m_chipselect && m_read) begin
      case (m_address)
        3'd0: m_readdata <= {16'd0,
                             (fifo.size() > 255) ? 8'hFF : 8'(fifo.size()),
                             8'd0};
        3'd1: begin
          if (fifo.size() != 0) m_readdata <= fifo.pop_front();
          else                  m_readdata <= 32'd0;
        end
        3'd2: m_readdata <= id_val;
        default: m_readdata <= 32'd0;
      endcase
    end
    if (m_chipselect && m_write && m_address == 3'd0 && m_writedata[4])
      fifo.delete();
  end

  // Bus monitor.
  int cyc = 0;
  int n_rd = 0, n_wr = 0, n_msg = 0, n_valid = 0, b2b = 0, cs_bad = 0;
  int wr_cyc = 0;
  logic [31:0] wr_data = '0;
  logic [2:0]  wr_addr = '0;
  logic rd_prev = 1'b0;
  int stat_t[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (m_read && rd_prev) b2b++;
    rd_prev = m_read;
    if (m_chipselect !== (m_read | m_write)) cs_bad++;
    if (m_read) begin
      n_rd++;
      if (m_address == 3'd1) n_msg++;
      if (m_address == 3'd0) stat_t.push_back(cyc);
    end
    if (m_write) begin
      n_wr++;
      wr_cyc  = cyc;
      wr_data = m_writedata;
      wr_addr = m_address;
    end
    if (bb_valid) n_valid++;
  end

  int exp_resync = 0;

  task automatic clear_mon();
    n_rd = 0; n_wr = 0; n_msg = 0;
    stat_t.delete();
  endtask

  task automatic release_reset(output int c0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    c0 = cyc;
    exp_resync = 0;
    @(negedge clk);
    chk("id_rd", 32'(m_read), 1);
    chk("id_addr", 32'(m_address), 2);
  endtask

  task automatic send_msg(input bit junk, input int x0, input int y0,
                          input int x1, input int y1);
    int nv;
    int t;
    if (junk) begin
      fifo.push_back(32'hDEAD_BEEF);
      exp_resync = (exp_resync < 255) ? exp_resync + 1 : 255;
    end
    fifo.push_back(RBB);
    fifo.push_back({5'($urandom), 11'(x0), 5'($urandom), 11'(y0)});
    fifo.push_back({5'($urandom), 11'(x1), 5'($urandom), 11'(y1)});
    nv = n_valid;
    t = 0;
    while (!bb_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("valid_timeout", 32'(t >= 300), 0);
    chk("left", 32'(bb_left), 32'(x0));
    chk("top", 32'(bb_top), 32'(y0));
    chk("right", 32'(bb_right), 32'(x1));
    chk("bottom", 32'(bb_bottom), 32'(y1));
    chk("found", 32'(bb_found), 32'((x0 <= x1) && (y0 <= y1)));
    repeat (P + 6) @(negedge clk);
    chk("valid_once", 32'(n_valid - nv), 1);
    chk("resync", 32'(resync_count), 32'(exp_resync));
  endtask

  initial begin
    int c0;
    int t;
    int nv;
    int x0, y0, x1, y1;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_read", 32'(m_read), 0);
    chk("rst_cs", 32'(m_chipselect), 0);
    chk("rst_write", 32'(m_write), 0);
    chk("rst_valid", 32'(bb_valid), 0);
    chk("rst_idok", 32'(id_ok), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_resync", 32'(resync_count), 0);
    chk("rst_box", 32'({bb_left, bb_top, bb_right}), 0);

    // Idle polling with an empty FIFO.
    clear_mon();
    release_reset(c0);
    repeat (4 * (P + 3) + 4) @(negedge clk);
    chk("idok", 32'(id_ok), 1);
    chk("no_fault", 32'(fault), 0);
    chk("n_flush", 32'(n_wr), 1);
    chk("flush_addr", 32'(wr_addr), 0);
    chk("flush_data", wr_data, 32'h10);
    chk("flush_cyc", 32'(wr_cyc - c0), 2);
    chk("no_msg_rd", 32'(n_msg), 0);
    chk("n_stat", 32'(stat_t.size() >= 3), 1);
    if (stat_t.size() >= 3) begin
      chk("first_stat", 32'(stat_t[0] - c0), 32'(P + 4));
      chk("stat_gap1", 32'(stat_t[1] - stat_t[0]), 32'(P + 3));
      chk("stat_gap2", 32'(stat_t[2] - stat_t[1]), 32'(P + 3));
    end

    // Directed boxes, including the empty frame and a resync.
    send_msg(1'b0, 100, 50, 300, 200);
    send_msg(1'b0, 639, 479, 0, 0);
    send_msg(1'b1, 12, 34, 56, 78);
    send_msg(1'b0, 2047, 0, 2047, 0);

    // Random boxes, some degenerate, some with a junk word first.
    for (int i = 0; i < 10; i++) begin
      x0 = $urandom_range(0, 2047);
      y0 = $urandom_range(0, 2047);
      x1 = ($urandom_range(0, 3) == 0) ? x0 : $urandom_range(0, 2047);
      y1 = ($urandom_range(0, 3) == 0) ? y0 : $urandom_range(0, 2047);
      send_msg($urandom_range(0, 3) == 0, x0, y0, x1, y1);
    end

    // Saturation: 302 junk words yield 300 header rejections.
    for (int i = 0; i < 302; i++) fifo.push_back(32'hBAD0_0000 + 32'(i));
    t = 0;
    while (fifo.size() > 2 && t < 302 * (P + 8)) begin
      @(negedge clk);
      t++;
    end
    chk("sat_timeout", 32'(t >= 302 * (P + 8)), 0);
    repeat (4) @(negedge clk);
    exp_resync = (exp_resync + 300 > 255) ? 255 : exp_resync + 300;
    chk("resync_sat", 32'(resync_count), 32'(exp_resync));

    // Reset clears state; the flush discards the leftover words.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    clear_mon();
    release_reset(c0);
    repeat (6) @(negedge clk);
    chk("flush_clear", 32'(fifo.size()), 0);
    chk("resync_rst", 32'(resync_count), 0);
    send_msg(1'b0, 7, 8, 9, 10);

    // Reset between TL_WAIT and BR_RD abandons the message.
    fifo.push_back(RBB);
    fifo.push_back({5'd0, 11'd400, 5'd0, 11'd300});
    fifo.push_back({5'd0, 11'd500, 5'd0, 11'd350});
    t = 0;
    while (fifo.size() != 1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("tl_timeout", 32'(t >= 100), 0);
    nv = n_valid;
    reset_n = 1'b0;
    #1;
    chk("mid_box", 32'({bb_left, bb_top, bb_right}), 0);
    chk("mid_bottom", 32'(bb_bottom), 0);
    chk("mid_idok", 32'(id_ok), 0);
    chk("mid_read", 32'(m_read), 0);
    repeat (3) @(negedge clk);
    clear_mon();
    release_reset(c0);
    repeat (6) @(negedge clk);
    chk("mid_no_valid", 32'(n_valid - nv), 0);
    chk("mid_flush", 32'(n_wr), 1);
    chk("mid_residue", 32'(fifo.size()), 0);
    send_msg(1'b0, 1, 2, 3, 4);

    // ID mismatch locks the block in FAULT with a silent bus.
    reset_n = 1'b0;
    id_val = 32'h0;
    repeat (2) @(negedge clk);
    release_reset(c0);
    repeat (3) @(negedge clk);
    chk("fault", 32'(fault), 1);
    chk("fault_idok", 32'(id_ok), 0);
    clear_mon();
    repeat (1000) @(negedge clk);
    chk("fault_quiet", 32'(n_rd + n_wr), 0);
    chk("fault_held", 32'(fault), 1);

    chk("rd_back2back", 32'(b2b), 0);
    chk("cs_consistent", 32'(cs_bad), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
